// File: rtl/scan_xfer_arbiter.sv
// Round-robin arbiter and sequencer for the pseudo-SPI scan engine.
// Grants one of two requesters, optionally pulses the scan SEL line, then runs and supervises a transfer.
module scan_xfer_arbiter #(
  parameter int unsigned MEMORY_ADDR_WIDTH = 9,
  parameter int unsigned RESERVED_DATA_LEN = 8,
  parameter int unsigned CAPT_CYCLES       = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         REQ0,
  input  logic                         REQ1,
  input  logic [MEMORY_ADDR_WIDTH-1:0] R0_ADDR,
  input  logic [MEMORY_ADDR_WIDTH-1:0] R1_ADDR,
  input  logic [RESERVED_DATA_LEN-1:0] R0_LEN,
  input  logic [RESERVED_DATA_LEN-1:0] R1_LEN,
  input  logic [7:0]                   R0_DIV,
  input  logic [7:0]                   R1_DIV,
  input  logic                         R0_CAP,
  input  logic                         R1_CAP,
  output logic                         ACK0,
  output logic                         ACK1,
  output logic                         ERR0,
  output logic                         ERR1,
  output logic                         SPI_BGN,
  output logic [MEMORY_ADDR_WIDTH-1:0] SPI_ADDR_BGN,
  output logic [RESERVED_DATA_LEN-1:0] SPI_DATA_LEN,
  output logic [7:0]                   SPI_FREQ_DIV,
  input  logic                         SPI_DONE,
  output logic                         SC_SEL,
  output logic                         BUSY,
  output logic                         OWNER
);

  localparam int unsigned CaptW = $clog2(CAPT_CYCLES + 1);
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CaptW-1:0] CaptLast = CaptW'(CAPT_CYCLES - 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StCapt,
    StRun,
    StWait,
    StRelease
  } state_e;

  state_e                       state_q, state_d;
  logic                         owner_q, owner_d;
  logic                         busy_q, busy_d;
  logic                         bgn_q, bgn_d;
  logic                         sel_q, sel_d;
  logic                         cap_q, cap_d;
  logic                         ack0_q, ack0_d, ack1_q, ack1_d;
  logic                         err0_q, err0_d, err1_q, err1_d;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RESERVED_DATA_LEN-1:0] len_q, len_d;
  logic [7:0]                   div_q, div_d;
  logic [CaptW-1:0]             capt_cnt_q, capt_cnt_d;
  logic [WdogW-1:0]             wdog_q, wdog_d;
  logic                         grant;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    bgn_d      = bgn_q;
    sel_d      = sel_q;
    cap_d      = cap_q;
    addr_d     = addr_q;
    len_d      = len_q;
    div_d      = div_q;
    capt_cnt_d = capt_cnt_q;
    wdog_d     = wdog_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    grant      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (REQ0 || REQ1) begin
          // Contention goes to whoever did not hold the last grant.
          grant   = (REQ0 && REQ1) ? ~owner_q : REQ1;
          owner_d = grant;
          addr_d  = grant ? R1_ADDR : R0_ADDR;
          len_d   = grant ? R1_LEN  : R0_LEN;
          div_d   = grant ? R1_DIV  : R0_DIV;
          cap_d   = grant ? R1_CAP  : R0_CAP;
          state_d = StCheck;
        end
      end

      StCheck: begin
        if (32'(addr_q) < 32'(len_q)) begin
          err0_d  = ~owner_q;
          err1_d  = owner_q;
          state_d = StIdle;
        end else if (cap_q) begin
          sel_d      = 1'b1;
          capt_cnt_d = '0;
          state_d    = StCapt;
        end else begin
          state_d = StRun;
        end
      end

      StCapt: begin
        if (capt_cnt_q == CaptLast) begin
          sel_d   = 1'b0;
          state_d = StRun;
        end else begin
          capt_cnt_d = capt_cnt_q + 1'b1;
        end
      end

      StRun: begin
        // A done still high from the previous transfer must clear before starting.
        if (!SPI_DONE) begin
          bgn_d   = 1'b1;
          wdog_d  = '0;
          state_d = StWait;
        end
      end

      StWait: begin
        if (SPI_DONE) begin
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          bgn_d   = 1'b0;
          state_d = StRelease;
        end else if (wdog_q == WdogLast) begin
          err0_d  = ~owner_q;
          err1_d  = owner_q;
          bgn_d   = 1'b0;
          state_d = StRelease;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      StRelease: begin
        wdog_d = '0;
        if (!SPI_DONE) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        bgn_d   = 1'b0;
        sel_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      owner_q    <= 1'b1;
      busy_q     <= 1'b0;
      bgn_q      <= 1'b0;
      sel_q      <= 1'b0;
      cap_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      div_q      <= '0;
      capt_cnt_q <= '0;
      wdog_q     <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      bgn_q      <= bgn_d;
      sel_q      <= sel_d;
      cap_q      <= cap_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      div_q      <= div_d;
      capt_cnt_q <= capt_cnt_d;
      wdog_q     <= wdog_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  assign ACK0         = ack0_q;
  assign ACK1         = ack1_q;
  assign ERR0         = err0_q;
  assign ERR1         = err1_q;
  assign SPI_BGN      = bgn_q;
  assign SC_SEL       = sel_q;
  assign BUSY         = busy_q;
  assign OWNER        = owner_q;
  assign SPI_ADDR_BGN = addr_q;
  assign SPI_DATA_LEN = len_q;
  assign SPI_FREQ_DIV = div_q;

endmodule

// File: tb/tb_scan_xfer_arbiter.sv
// Self-checking bench for scan_xfer_arbiter: a timeline model of each transfer predicts every
// output per cycle, a simple engine stand-in answers SPI_BGN, and directed tests pin exact timings.
module tb_scan_xfer_arbiter;

  localparam int unsigned AW   = 9;
  localparam int unsigned LW   = 8;
  localparam int unsigned CAPT = 4;
  localparam int unsigned TMO  = 200;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0, REQ1;
  logic [AW-1:0] R0_ADDR, R1_ADDR;
  logic [LW-1:0] R0_LEN, R1_LEN;
  logic [7:0]    R0_DIV, R1_DIV;
  logic          R0_CAP, R1_CAP;
  logic          ACK0, ACK1, ERR0, ERR1;
  logic          SPI_BGN;
  logic [AW-1:0] SPI_ADDR_BGN;
  logic [LW-1:0] SPI_DATA_LEN;
  logic [7:0]    SPI_FREQ_DIV;
  logic          SPI_DONE;
  logic          SC_SEL, BUSY, OWNER;

  always #5 CLK = ~CLK;

  scan_xfer_arbiter #(
    .MEMORY_ADDR_WIDTH(AW),
    .RESERVED_DATA_LEN(LW),
    .CAPT_CYCLES(CAPT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
    .R0_ADDR(R0_ADDR), .R1_ADDR(R1_ADDR), .R0_LEN(R0_LEN), .R1_LEN(R1_LEN),
    .R0_DIV(R0_DIV), .R1_DIV(R1_DIV), .R0_CAP(R0_CAP), .R1_CAP(R1_CAP),
    .ACK0(ACK0), .ACK1(ACK1), .ERR0(ERR0), .ERR1(ERR1),
    .SPI_BGN(SPI_BGN), .SPI_ADDR_BGN(SPI_ADDR_BGN), .SPI_DATA_LEN(SPI_DATA_LEN),
    .SPI_FREQ_DIV(SPI_FREQ_DIV), .SPI_DONE(SPI_DONE), .SC_SEL(SC_SEL), .BUSY(BUSY),
    .OWNER(OWNER)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one thread walks each transfer's timeline ----------------
  logic          e_bgn, e_sel, e_ack0, e_ack1, e_err0, e_err1, e_busy, e_owner;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_len;
  logic [7:0]    e_div;

  function automatic void set_reset_exp();
    e_bgn = 0; e_sel = 0; e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
    e_busy = 0; e_owner = 1; e_addr = '0; e_len = '0; e_div = '0;
  endfunction

  function automatic void finish_pulse(input bit ok);
    if (ok) begin
      if (e_owner) e_ack1 = 1; else e_ack0 = 1;
    end else begin
      if (e_owner) e_err1 = 1; else e_err0 = 1;
    end
  endfunction

  task automatic step(output bit rst_hit);
    @(posedge CLK);
    e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
    rst_hit = RST;
    if (RST) set_reset_exp();
  endtask

  task automatic model_transfer(input bit cap);
    bit r;
    int waited;
    step(r); if (r) return;
    if (32'(e_addr) < 32'(e_len)) begin
      finish_pulse(1'b0);
      e_busy = 0;
      return;
    end
    if (cap) begin
      e_sel = 1;
      for (int i = 0; i < int'(CAPT); i++) begin
        step(r); if (r) return;
      end
      e_sel = 0;
    end
    do begin
      step(r); if (r) return;
    end while (SPI_DONE);
    e_bgn  = 1;
    waited = 0;
    forever begin
      step(r); if (r) return;
      waited++;
      if (SPI_DONE) begin
        e_bgn = 0; finish_pulse(1'b1); break;
      end
      if (waited == int'(TMO)) begin
        e_bgn = 0; finish_pulse(1'b0); break;
      end
    end
    do begin
      step(r); if (r) return;
    end while (SPI_DONE);
    e_busy = 0;
  endtask

  initial begin : model
    bit r;
    bit g;
    set_reset_exp();
    forever begin
      step(r);
      if (r) continue;
      if (REQ0 || REQ1) begin
        g       = (REQ0 && REQ1) ? ~e_owner : REQ1;
        e_owner = g;
        e_busy  = 1;
        e_addr  = g ? R1_ADDR : R0_ADDR;
        e_len   = g ? R1_LEN  : R0_LEN;
        e_div   = g ? R1_DIV  : R0_DIV;
        model_transfer(g ? R1_CAP : R0_CAP);
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("spi_bgn",  32'(SPI_BGN),      32'(e_bgn));
      chk("sc_sel",   32'(SC_SEL),       32'(e_sel));
      chk("ack0",     32'(ACK0),         32'(e_ack0));
      chk("ack1",     32'(ACK1),         32'(e_ack1));
      chk("err0",     32'(ERR0),         32'(e_err0));
      chk("err1",     32'(ERR1),         32'(e_err1));
      chk("busy",     32'(BUSY),         32'(e_busy));
      chk("owner",    32'(OWNER),        32'(e_owner));
      chk("addr_bgn", 32'(SPI_ADDR_BGN), 32'(e_addr));
      chk("data_len", 32'(SPI_DATA_LEN), 32'(e_len));
      chk("freq_div", 32'(SPI_FREQ_DIV), 32'(e_div));
      chk("one_pulse", 32'($countones({ACK0, ACK1, ERR0, ERR1}) <= 1), 32'(1));
    end
  end

  // ---------------- engine stand-in ----------------
  int unsigned lat_min = 1, lat_max = 1, drop_max = 1, hang_pct = 0;
  int unsigned eng_cnt, eng_lat, eng_drop;
  bit          eng_active = 0, eng_stall = 0;

  initial begin
    SPI_DONE = 0;
    forever begin
      @(posedge CLK); #1;
      if (SPI_BGN) begin
        if (!eng_active) begin
          eng_active = 1;
          eng_cnt    = 0;
          eng_lat    = $urandom_range(lat_max, lat_min);
          eng_stall  = ($urandom_range(99, 0) < hang_pct);
        end
        if (!eng_stall && !SPI_DONE) begin
          if (eng_cnt >= eng_lat) begin
            SPI_DONE = 1;
            eng_drop = $urandom_range(drop_max, 0);
          end else begin
            eng_cnt++;
          end
        end
      end else begin
        eng_active = 0;
        if (SPI_DONE) begin
          if (eng_drop == 0) SPI_DONE = 0;
          else eng_drop--;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK); #1;
    if (ACK0 || ERR0) REQ0 = 0;
    if (ACK1 || ERR1) REQ1 = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((BUSY || REQ0 || REQ1) && n < 1000) begin
      cyc(); n++;
    end
    chk("idle_reached", 32'(BUSY), 32'(0));
  endtask

  task automatic rand_desc(input bit which);
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    a = ($urandom_range(3, 0) == 0) ? AW'($urandom_range(7, 0)) : AW'($urandom);
    l = ($urandom_range(1, 0) == 0) ? LW'($urandom_range(15, 0)) : LW'($urandom);
    if (which) begin
      R1_ADDR = a; R1_LEN = l; R1_DIV = 8'($urandom); R1_CAP = 1'($urandom);
    end else begin
      R0_ADDR = a; R0_LEN = l; R0_DIV = 8'($urandom); R0_CAP = 1'($urandom);
    end
  endtask

  int n, sel_cnt, ng;
  bit bgn_seen, pb;
  logic grants [4];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running, expected to finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    RST = 1; REQ0 = 0; REQ1 = 0;
    R0_ADDR = '0; R1_ADDR = '0; R0_LEN = '0; R1_LEN = '0;
    R0_DIV = '0; R1_DIV = '0; R0_CAP = 0; R1_CAP = 0;
    cyc();
    chk_en = 1;
    cyc();
    chk("rst_owner", 32'(OWNER), 32'(1));
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_bgn", 32'(SPI_BGN), 32'(0));
    chk("rst_addr", 32'(SPI_ADDR_BGN), 32'(0));
    RST = 0;
    cyc();

    // Single request, no capture, slow engine
    lat_min = 180; lat_max = 180;
    R0_ADDR = 1; R0_LEN = 1; R0_DIV = 0; R0_CAP = 0; REQ0 = 1;
    n = 0;
    do begin cyc(); n++; end while (!SPI_BGN && n < 20);
    chk("t1_bgn_latency", 32'(n), 32'(3));
    chk("t1_addr", 32'(SPI_ADDR_BGN), 32'(1));
    chk("t1_len", 32'(SPI_DATA_LEN), 32'(1));
    n = 0;
    while (!ACK0 && n < 400) begin cyc(); n++; end
    chk("t1_ack0", 32'(ACK0), 32'(1));
    cyc();
    chk("t1_ack0_single", 32'(ACK0), 32'(0));
    wait_idle();
    chk("t1_addr_frozen", 32'(SPI_ADDR_BGN), 32'(1));

    // Capture phase on requester 1
    lat_min = 5; lat_max = 5;
    R1_ADDR = 40; R1_LEN = 7; R1_DIV = 3; R1_CAP = 1; REQ1 = 1;
    n = 0; sel_cnt = 0;
    do begin
      cyc(); n++;
      if (SC_SEL) sel_cnt++;
    end while (!SPI_BGN && n < 40);
    chk("capt_bgn_latency", 32'(n), 32'(3 + CAPT));
    chk("capt_sel_cycles", 32'(sel_cnt), 32'(CAPT));
    chk("capt_owner", 32'(OWNER), 32'(1));
    chk("capt_div", 32'(SPI_FREQ_DIV), 32'(3));
    n = 0;
    while (!ACK1 && n < 100) begin cyc(); n++; end
    chk("capt_ack1", 32'(ACK1), 32'(1));
    wait_idle();

    // Contention from reset: grants must alternate starting with requester 0
    RST = 1; cyc(); RST = 0;
    lat_min = 3; lat_max = 8;
    R0_ADDR = 10; R0_LEN = 2; R0_CAP = 0;
    R1_ADDR = 30; R1_LEN = 4; R1_CAP = 1;
    REQ0 = 1; REQ1 = 1;
    ng = 0; n = 0; pb = BUSY;
    while (ng < 4 && n < 600) begin
      cyc(); n++;
      if (BUSY && !pb) begin grants[ng] = OWNER; ng++; end
      pb = BUSY;
      if (!REQ0) REQ0 = 1;
      if (!REQ1) REQ1 = 1;
    end
    REQ0 = 0; REQ1 = 0;
    wait_idle();
    chk("cont_grants", 32'(ng), 32'(4));
    chk("cont_g0", 32'(grants[0]), 32'(0));
    chk("cont_g1", 32'(grants[1]), 32'(1));
    chk("cont_g2", 32'(grants[2]), 32'(0));
    chk("cont_g3", 32'(grants[3]), 32'(1));

    // Underflowing descriptor is rejected without starting the engine
    R0_ADDR = 0; R0_LEN = 3; R0_CAP = 0; REQ0 = 1;
    n = 0; bgn_seen = 0;
    do begin
      cyc(); n++;
      if (SPI_BGN) bgn_seen = 1;
    end while (!ERR0 && n < 20);
    chk("bad_err_latency", 32'(n), 32'(2));
    chk("bad_err0", 32'(ERR0), 32'(1));
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (SPI_BGN) bgn_seen = 1;
    end
    chk("bad_no_bgn", 32'(bgn_seen), 32'(0));
    R0_ADDR = 5; R0_LEN = 2; REQ0 = 1;
    n = 0;
    while (!ACK0 && n < 100) begin cyc(); n++; end
    chk("bad_next_ack0", 32'(ACK0), 32'(1));
    wait_idle();

    // Watchdog: engine never answers
    hang_pct = 100;
    R1_ADDR = 20; R1_LEN = 3; R1_CAP = 0; REQ1 = 1;
    n = 0;
    while (!SPI_BGN && n < 20) begin cyc(); n++; end
    n = 0;
    while (!ERR1 && n < int'(TMO) + 20) begin cyc(); n++; end
    chk("tmo_cycles", 32'(n), 32'(TMO));
    chk("tmo_err1", 32'(ERR1), 32'(1));
    chk("tmo_bgn_low", 32'(SPI_BGN), 32'(0));
    cyc();
    chk("tmo_idle", 32'(BUSY), 32'(0));
    hang_pct = 0;

    // Reset during WAIT
    lat_min = 50; lat_max = 50;
    R0_ADDR = 100; R0_LEN = 9; R0_CAP = 0; REQ0 = 1;
    n = 0;
    while (!SPI_BGN && n < 20) begin cyc(); n++; end
    cyc(); cyc(); cyc();
    RST = 1;
    cyc();
    RST = 0;
    chk("mrst_bgn", 32'(SPI_BGN), 32'(0));
    chk("mrst_sel", 32'(SC_SEL), 32'(0));
    chk("mrst_busy", 32'(BUSY), 32'(0));
    chk("mrst_owner", 32'(OWNER), 32'(1));
    chk("mrst_addr", 32'(SPI_ADDR_BGN), 32'(0));
    chk("mrst_len", 32'(SPI_DATA_LEN), 32'(0));
    chk("mrst_pulses", 32'({ACK0, ACK1, ERR0, ERR1}), 32'(0));
    chk("mrst_model_owner", 32'(e_owner), 32'(1));
    lat_min = 2; lat_max = 10;
    R1_ADDR = 50; R1_LEN = 5; R1_CAP = 1; REQ1 = 1;
    cyc();
    chk("mrst_regrant_owner", 32'(OWNER), 32'(0));
    chk("mrst_regrant_busy", 32'(BUSY), 32'(1));
    wait_idle();

    // Randomized traffic with stale done, hangs and occasional resets
    lat_min = 1; lat_max = 12; drop_max = 3; hang_pct = 3;
    for (int c = 0; c < 4000; c++) begin
      cyc();
      RST = ($urandom_range(599, 0) == 0);
      if (!REQ0 && $urandom_range(3, 0) == 0) begin rand_desc(1'b0); REQ0 = 1; end
      if (!REQ1 && $urandom_range(3, 0) == 0) begin rand_desc(1'b1); REQ1 = 1; end
    end
    RST = 0; hang_pct = 0;
    wait_idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_xfer_arbiter.md
# scan_xfer_arbiter

Sequencer and two-port arbiter for the pseudo-SPI scan engine (`PSEUDO_SPT_INTF`). It accepts transfer descriptors from two requesters: requester 0 is the CPU configuration path, requester 1 is the ADC/CFSA capture logic. It grants the engine round-robin, optionally runs a scan-capture phase on the chain `SEL` line, then drives `BGN`/`ADDR_BGN`/`DATA_LEN`/`FREQ_DIV` and waits for `spi_is_done`. Completion is acknowledged per requester, and a watchdog aborts hung transfers.

## Interface
Parameters:
- `MEMORY_ADDR_WIDTH`, 9, SRAM address width.
- `RESERVED_DATA_LEN`, 8, width of the length field.
- `CAPT_CYCLES`, 4, number of cycles `SC_SEL` is held high in the capture phase (≥1).
- `TIMEOUT_CYCLES`, 4096, watchdog limit in the WAIT state (≥2).

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `REQ0`, `REQ1` in 1: request levels. The requester holds `REQx` high, with its descriptor stable, until `ACKx` or `ERRx`.
- `R0_ADDR`, `R1_ADDR` in `MEMORY_ADDR_WIDTH`: transfer end address.
- `R0_LEN`, `R1_LEN` in `RESERVED_DATA_LEN`: byte count minus 1.
- `R0_DIV`, `R1_DIV` in 8: SCLK frequency divider.
- `R0_CAP`, `R1_CAP` in 1: 1 runs the capture phase before shifting.
- `ACK0`, `ACK1` out 1: one-cycle pulse on successful completion.
- `ERR0`, `ERR1` out 1: one-cycle pulse on a rejected descriptor or a timeout.
- `SPI_BGN` out 1: enable to the engine's `BGN`.
- `SPI_ADDR_BGN` out `MEMORY_ADDR_WIDTH`: to the engine's `ADDR_BGN`.
- `SPI_DATA_LEN` out `RESERVED_DATA_LEN`: to the engine's `DATA_LEN`.
- `SPI_FREQ_DIV` out 8: to the engine's `FREQ_DIV`.
- `SPI_DONE` in 1: from the engine's `spi_is_done`.
- `SC_SEL` out 1: scan-cell `SEL` (capture of `PIN`).
- `BUSY` out 1: high whenever not in IDLE.
- `OWNER` out 1: index of the current grant; holds its value while idle.

## Operation
- All outputs are registered.
- Reset values: `SPI_BGN`=0, `SC_SEL`=0, all `ACKx`/`ERRx`=0, `BUSY`=0, `OWNER`=1 (so requester 0 wins the first tie), `SPI_ADDR_BGN`/`SPI_DATA_LEN`/`SPI_FREQ_DIV`=0, state IDLE, watchdog=0.
- The state machine has six states: IDLE, CHECK, CAPT, RUN, WAIT, RELEASE.
- IDLE:
  - With one request high, grant it.
  - With both high, grant `!OWNER` (round-robin).
  - On grant, latch the descriptor into the `SPI_*` registers, set `OWNER`, and go to CHECK.
- CHECK:
  - If `ADDR < LEN`, the transfer would underflow the start address. Pulse `ERRx` and go to IDLE. The engine is never started.
  - Otherwise go to CAPT if `CAP`=1, else RUN.
- CAPT: hold `SC_SEL`=1 for exactly `CAPT_CYCLES` cycles, then deassert it and go to RUN.
- RUN:
  - If `SPI_DONE` is already 1 (stale from the previous transfer), stay in RUN with `SPI_BGN`=0 until it falls.
  - Otherwise set `SPI_BGN`=1 and go to WAIT.
- WAIT:
  - Hold `SPI_BGN`=1 and increment the watchdog.
  - When `SPI_DONE`=1, pulse `ACKx`, drop `SPI_BGN`, and go to RELEASE.
  - When the watchdog reaches `TIMEOUT_CYCLES`, pulse `ERRx`, drop `SPI_BGN`, and go to RELEASE.
- RELEASE: clear the watchdog and wait for `SPI_DONE`=0, then go to IDLE. There is no watchdog in this state.
- If the owner drops `REQx` mid-transfer, the transfer runs to completion. `ACKx` is still pulsed, and the requester ignores it.
- `SPI_*` descriptor outputs are frozen from the latch until the next grant, so the engine sees stable configuration for the whole transfer.
- `RST` in any state returns to reset values on the next edge. This includes dropping `SPI_BGN` and `SC_SEL` mid-transfer. No `ACK`/`ERR` is emitted.

## Timing
- `REQx` is sampled high in IDLE at edge t. `OWNER`/`BUSY`/`SPI_*` are valid after edge t; CHECK occupies cycle t+1.
- With `CAP`=0: `SPI_BGN` rises after edge t+2.
- With `CAP`=1: `SC_SEL` is high for cycles t+2 … t+1+`CAPT_CYCLES`, and `SPI_BGN` rises after edge t+2+`CAPT_CYCLES`.
- The `ACKx` pulse coincides with the first cycle in which `SPI_BGN` is 0 after `SPI_DONE` is seen.
- Minimum gap between two grants is 2 cycles, provided `SPI_DONE` falls one cycle after `BGN` drops.
- `ACKx` and `ERRx` are never high in the same cycle. At most one of the four pulses is high in any cycle.

## Test plan
- Single request, no capture: `REQ0` with ADDR=1, LEN=1, DIV=0, `CAP`=0; engine done after 180 cycles → `SPI_BGN` high 2 cycles after the request, `ACK0` one pulse, `SPI_ADDR_BGN`=1, `SPI_DATA_LEN`=1, `BUSY` back to 0.
- Capture + scan: `REQ1` with `CAP`=1, `CAPT_CYCLES`=4, ADC=10'h2AF; run the real engine with the 14-cell chain → `SC_SEL` high exactly 4 cycles, then the shifted 16 bits reproduce 10'h2AF in bits [11:2], then `ACK1`.
- Contention: `REQ0` and `REQ1` both high from reset, each re-requesting after its ack → grants alternate 0,1,0,1 over 4 transfers, with no overlap of `SPI_BGN` periods.
- Bad descriptor: `REQ0` with ADDR=0, LEN=3 → `ERR0` at cycle t+2, `SPI_BGN` never asserted, next request is served normally.
- Timeout: `TIMEOUT_CYCLES`=16, `SPI_DONE` tied 0 → `ERR1` after 16 WAIT cycles, `SPI_BGN`=0, state stays in RELEASE until `SPI_DONE`=0, then IDLE.
- Reset mid-WAIT: assert `RST` for one cycle during WAIT → next cycle all outputs are at reset values, no `ACK`/`ERR`, and a fresh request is granted to requester 0.
